// File: rtl/floo_test_sequencer.sv
// floo_test_sequencer: starts NumNodes traffic generators (all at once or in index order) and collects completion.
// Optional watchdog enabled by defining FLOO_TEST_SEQUENCER_TIMEOUT_EN.
`default_nettype none

module floo_test_sequencer #(
  parameter int NumNodes      = 4,
  parameter int TimeoutCycles = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                seq_mode_i,
  output logic [NumNodes-1:0] node_start_o,
  input  logic [NumNodes-1:0] node_done_i,
  output logic [NumNodes-1:0] done_mask_o,
  output logic                busy_o,
  output logic                end_of_sim_o,
  output logic                timeout_o
);

  localparam int PtrW = (NumNodes > 1) ? $clog2(NumNodes) : 1;
  localparam logic [NumNodes-1:0] AllNodes  = {NumNodes{1'b1}};
  localparam logic [NumNodes-1:0] FirstNode = NumNodes'(1);

`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
    DONE    = 2'd2,
    TIMEOUT = 2'd3
`else
    DONE    = 2'd2
`endif
  } state_t;

  state_t              state, state_n;
  logic                seq_mode, seq_mode_n;
  logic [NumNodes-1:0] started, started_n;
  logic [NumNodes-1:0] start_n;
  logic [NumNodes-1:0] mask_n;
  logic [NumNodes-1:0] capture;
  logic [NumNodes-1:0] advance;
  logic [PtrW-1:0]     ptr, ptr_n;
  logic                busy_n;
  logic                eos_n;

`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
  logic [CntW-1:0]     cnt, cnt_n;
  logic                timeout_n;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      seq_mode     <= 1'b0;
      started      <= '0;
      ptr          <= '0;
      node_start_o <= '0;
      done_mask_o  <= '0;
      busy_o       <= 1'b0;
      end_of_sim_o <= 1'b0;
    end else begin
      state        <= state_n;
      seq_mode     <= seq_mode_n;
      started      <= started_n;
      ptr          <= ptr_n;
      node_start_o <= start_n;
      done_mask_o  <= mask_n;
      busy_o       <= busy_n;
      end_of_sim_o <= eos_n;
    end
  end

`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      timeout_o <= timeout_n;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    seq_mode_n = seq_mode;
    started_n  = started;
    ptr_n      = ptr;
    start_n    = '0;
    mask_n     = done_mask_o;
    capture    = '0;
    advance    = '0;
`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
    cnt_n      = cnt;
`endif

    case (state)
      IDLE: begin
        if (start_i) begin
          state_n    = RUN;
          seq_mode_n = seq_mode_i;
          start_n    = seq_mode_i ? FirstNode : AllNodes;
          started_n  = start_n;
          ptr_n      = '0;
`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
          cnt_n      = '0;
`endif
        end
      end

      RUN: begin
        // Completion from a node that has not been started yet is discarded.
        capture = node_done_i & started;
        mask_n  = done_mask_o | capture;
`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
        cnt_n   = cnt + 1'b1;
`endif
        if (done_mask_o == AllNodes) begin
          state_n = DONE;
`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
        end else if (cnt == CntLast) begin
          state_n = TIMEOUT;
`endif
        end

        // Sequential mode hands off to the next node in the same edge that captures the current one.
        if (seq_mode && (state_n == RUN)) begin
          for (int k = 0; k < NumNodes - 1; k++) begin
            if ((ptr == PtrW'(k)) && mask_n[k] && !started[k+1]) begin
              advance[k+1] = 1'b1;
            end
          end
        end
        start_n   = advance;
        started_n = started | advance;
        if (advance != '0) begin
          ptr_n = ptr + 1'b1;
        end
      end

      default: begin
      end
    endcase

    busy_n = (state_n == RUN);
`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
    eos_n     = (state_n == DONE) || (state_n == TIMEOUT);
    timeout_n = (state_n == TIMEOUT);
`else
    eos_n     = (state_n == DONE);
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_floo_test_sequencer.sv
// Scoreboard bench for floo_test_sequencer: expected start pulses, mask updates and end events are queued with their cycle.
`default_nettype none

module tb_floo_test_sequencer;

  localparam int N   = 4;
  localparam int TMO = 50;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [N-1:0] node_start;
  logic [N-1:0] node_done;
  logic [N-1:0] done_mask;
  logic         busy;
  logic         eos;
  logic         tmo;

  int cyc;
  int vec_cnt;
  int err_cnt;

  typedef struct {
    int           cyc;
    logic [N-1:0] val;
    logic         tmo;
  } ev_t;

  ev_t q_start[$];
  ev_t q_mask[$];
  ev_t q_end[$];

  logic [N-1:0] prev_mask;
  logic         prev_eos;

  floo_test_sequencer #(
    .NumNodes      (N),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .seq_mode_i   (mode),
    .node_start_o (node_start),
    .node_done_i  (node_done),
    .done_mask_o  (done_mask),
    .busy_o       (busy),
    .end_of_sim_o (eos),
    .timeout_o    (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_start(input int c, input logic [N-1:0] v);
    q_start.push_back('{c, v, 1'b0});
  endfunction

  function automatic void push_mask(input int c, input logic [N-1:0] v);
    q_mask.push_back('{c, v, 1'b0});
  endfunction

  function automatic void push_end(input int c, input logic t, input logic [N-1:0] v);
    q_end.push_back('{c, v, t});
  endfunction

  // Output monitor samples on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_mask <= '0;
      prev_eos  <= 1'b0;
    end else begin
      if (node_start != '0) begin
        if (q_start.size() == 0) begin
          chk("start_unexpected", node_start, 0);
        end else begin
          chk("start_val", node_start, q_start[0].val);
          chk("start_cyc", cyc, q_start[0].cyc);
          void'(q_start.pop_front());
        end
      end
      if (done_mask != prev_mask) begin
        if (q_mask.size() == 0) begin
          chk("mask_unexpected", done_mask, prev_mask);
        end else begin
          chk("mask_val", done_mask, q_mask[0].val);
          chk("mask_cyc", cyc, q_mask[0].cyc);
          void'(q_mask.pop_front());
        end
      end
      if (eos && !prev_eos) begin
        if (q_end.size() == 0) begin
          chk("end_unexpected", eos, 0);
        end else begin
          chk("end_cyc", cyc, q_end[0].cyc);
          chk("end_timeout", tmo, q_end[0].tmo);
          chk("end_mask", done_mask, q_end[0].val);
          void'(q_end.pop_front());
        end
      end
      prev_mask <= done_mask;
      prev_eos  <= eos;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_start.size() + q_mask.size() + q_end.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", q_start.size() + q_mask.size() + q_end.size(), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    node_done = '0;
    tick();
    tick();
    chk("rst_node_start", node_start, 0);
    chk("rst_done_mask", done_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eos", eos, 0);
    chk("rst_timeout", tmo, 0);
    q_start.delete();
    q_mask.delete();
    q_end.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_concurrent();
    int s;
    do_reset();
    s     = cyc;
    start = 1'b1;
    mode  = 1'b0;
    push_start(s + 1, 4'b1111);
    tick();
    start = 1'b0;
    chk("busy_run", busy, 1);
    to_cyc(s + 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    to_cyc(s + 10);
    node_done[2] = 1'b1;
    push_mask(s + 11, 4'b0100);
    to_cyc(s + 12);
    node_done[0] = 1'b1;
    node_done[3] = 1'b1;
    push_mask(s + 13, 4'b1101);
    to_cyc(s + 15);
    node_done[2] = 1'b0;
    to_cyc(s + 20);
    node_done[1] = 1'b1;
    push_mask(s + 21, 4'b1111);
    push_end(s + 22, 1'b0, 4'b1111);
    drain(20);
    chk("done_busy", busy, 0);
    chk("done_eos", eos, 1);
    chk("done_timeout", tmo, 0);
    start = 1'b1;
    mode  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("done_hold_eos", eos, 1);
    chk("done_hold_mask", done_mask, 4'b1111);
  endtask

  task automatic run_seq(input bit early3);
    int s;
    int st;
    logic [N-1:0] m;
    do_reset();
    if (early3) node_done = 4'b1000;
    tick();
    tick();
    s     = cyc;
    start = 1'b1;
    mode  = 1'b1;
    push_start(s + 1, 4'b0001);
    tick();
    start = 1'b0;
    mode  = 1'b0;
    st = s + 1;
    m  = '0;
    for (int k = 0; k < N; k++) begin
      if (early3 && k == 3) begin
        m[3] = 1'b1;
        push_mask(st + 1, m);
        push_end(st + 2, 1'b0, m);
      end else begin
        to_cyc(st + 5);
        node_done[k] = 1'b1;
        m[k] = 1'b1;
        push_mask(st + 6, m);
        if (k < N - 1) push_start(st + 6, 4'(1 << (k + 1)));
        else push_end(st + 7, 1'b0, m);
        st += 6;
      end
    end
    drain(30);
    chk("seq_eos", eos, 1);
    chk("seq_mask", done_mask, 4'b1111);
  endtask

  task automatic run_reset_mid();
    int s;
    do_reset();
    s     = cyc;
    start = 1'b1;
    push_start(s + 1, 4'b1111);
    tick();
    start = 1'b0;
    to_cyc(s + 3);
    node_done = 4'b0011;
    push_mask(s + 4, 4'b0011);
    to_cyc(s + 6);
    chk("mid_mask", done_mask, 4'b0011);
    rst = 1'b1;
    #1;
    chk("async_node_start", node_start, 0);
    chk("async_mask", done_mask, 0);
    chk("async_busy", busy, 0);
    chk("async_eos", eos, 0);
    chk("async_timeout", tmo, 0);
    tick();
    node_done = '0;
    tick();
    rst = 1'b0;
    tick();
    drain(2);
    s     = cyc;
    start = 1'b1;
    push_start(s + 1, 4'b1111);
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    drain(5);
  endtask

  task automatic run_timeout();
    int s;
    do_reset();
    s     = cyc;
    start = 1'b1;
    push_start(s + 1, 4'b1111);
    tick();
    start = 1'b0;
    to_cyc(s + 3);
    node_done = 4'b1101;
    push_mask(s + 4, 4'b1101);
`ifdef FLOO_TEST_SEQUENCER_TIMEOUT_EN
    push_end(s + 1 + TMO, 1'b1, 4'b1101);
    drain(TMO + 20);
    chk("tmo_flag", tmo, 1);
    chk("tmo_busy", busy, 0);
`else
    to_cyc(s + 2 * TMO);
    chk("nowd_timeout", tmo, 0);
    chk("nowd_eos", eos, 0);
    chk("nowd_busy", busy, 1);
    drain(1);
`endif
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    node_done = '0;
    run_concurrent();
    run_seq(1'b0);
    run_seq(1'b1);
    run_reset_mid();
    run_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
